// File: rtl/ysyx_22040237_issue_ctrl.sv
// Issue scheduler between decode and EXU: register scoreboard for RAW/WAW hazards,
// in-flight cap, drain mode for ebreak/fence/halt, and a saturating stall counter.
module ysyx_22040237_issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic              rs1_read_en_i,
    input  logic [4:0]        rs1_idx_i,
    input  logic              rs2_read_en_i,
    input  logic [4:0]        rs2_idx_i,
    input  logic              rd_wr_en_i,
    input  logic [4:0]        rd_idx_i,
    input  logic              ex_ready_i,
    output logic              issue_valid_o,
    input  logic              retire_valid_i,
    input  logic              retire_rd_wen_i,
    input  logic [4:0]        retire_rd_idx_i,
    input  logic              drain_req_i,
    output logic              drained_o,
    output logic              stall_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_DRAIN
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    state_t             r_state;
    state_t             w_stateNext;
    logic [31:0]        r_pending;
    logic [31:0]        w_pendingNext;
    logic [2:0]         r_inflight;
    logic [2:0]         w_inflightNext;
    logic [PERF_W-1:0]  r_stallCnt;
    logic               r_err;
    logic               w_hazard;
    logic               w_full;
    logic               w_fire;
    logic               w_retireErr;

    // Hazard check uses only the registered scoreboard, so a retire unblocks one cycle later.
    always_comb begin
        w_hazard = (rs1_read_en_i & r_pending[rs1_idx_i])
                 | (rs2_read_en_i & r_pending[rs2_idx_i])
                 | (rd_wr_en_i    & r_pending[rd_idx_i]);
        w_full        = (r_inflight == MAX_CNT);
        id_ready_o    = ex_ready_i & ~w_hazard & ~w_full & (r_state != S_DRAIN) & ~drain_req_i;
        w_fire        = id_valid_i & id_ready_o;
        issue_valid_o = w_fire;
        stall_o       = id_valid_i & ~id_ready_o;
        drained_o     = (r_state == S_DRAIN) & (r_inflight == 3'd0);
    end

    // Set after clear: a new writer issued alongside a retire to the same rd keeps the bit.
    always_comb begin
        w_pendingNext = r_pending;
        if (retire_valid_i & retire_rd_wen_i) begin
            w_pendingNext[retire_rd_idx_i] = 1'b0;
        end
        if (w_fire & rd_wr_en_i) begin
            w_pendingNext[rd_idx_i] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    always_comb begin
        w_inflightNext = r_inflight;
        w_retireErr    = retire_valid_i & (r_inflight == 3'd0);
        if (w_fire & ~retire_valid_i) begin
            w_inflightNext = r_inflight + 3'd1;
        end else if (~w_fire & retire_valid_i & (r_inflight != 3'd0)) begin
            w_inflightNext = r_inflight - 3'd1;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            S_RUN: begin
                if (drain_req_i)                    w_stateNext = S_DRAIN;
                else if (id_valid_i & ~id_ready_o)  w_stateNext = S_STALL;
            end
            S_STALL: begin
                if (drain_req_i)                    w_stateNext = S_DRAIN;
                else if (id_ready_o | ~id_valid_i)  w_stateNext = S_RUN;
            end
            S_DRAIN: begin
                if ((r_inflight == 3'd0) & ~drain_req_i) w_stateNext = S_RUN;
            end
            default: w_stateNext = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_pending  <= '0;
            r_inflight <= '0;
            r_stallCnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pending  <= w_pendingNext;
            r_inflight <= w_inflightNext;
            if (stall_o && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_retireErr) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;
    assign err_o       = r_err;

endmodule
